// File: rtl/vae_ctrl_pkg.sv
// Shared definitions for the VAE forward-pass control slice.
// Holds the sequencer state encoding and the default datapath geometry
// and pipeline latencies used by vae_forward_sequencer.
package vae_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLR       = 3'd1,
        ENC_FEED  = 3'd2,
        ENC_DRAIN = 3'd3,
        REPARAM   = 3'd4,
        DEC_FEED  = 3'd5,
        DEC_DRAIN = 3'd6,
        DONE      = 3'd7
    } vae_state_t;

    localparam int VAE_N_IN        = 9;
    localparam int VAE_N_LAT       = 2;
    localparam int VAE_ENC_LAT     = 3;
    localparam int VAE_REPARAM_LAT = 4;
    localparam int VAE_DEC_LAT     = 3;
    localparam int VAE_CNT_W       = 8;

endpackage

// File: rtl/vae_phase_timer.sv
// Load/decrement/expire down-counter shared by the wait phases.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   load          load load_val this cycle (has priority over decrement)
//   load_val      value to load (phase length - 1)
//   expired       count has reached 0
module vae_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/vae_forward_sequencer.sv
// Control FSM for one VAE inference: encoder feed/drain, reparameterization,
// decoder feed/drain, then a done pulse. All outputs are registered and
// reflect the state they belong to in the same cycle.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               launch a run (honoured only in IDLE)
//   abort               cancel a run, back to IDLE (ignored in IDLE)
//   x_valid             feature source has data for enc_idx
//   enc_clr, dec_clr    accumulator clears (CLR cycle)
//   enc_en, enc_idx     encoder consume strobe and feature index
//   reparam_en          one-cycle latch/RNG-step strobe
//   dec_en, dec_idx     decoder consume strobe and latent index
//   busy, done          run in progress, one-cycle completion pulse
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | waiting for start, all outputs low
// CLR       | clear both accumulator banks
// ENC_FEED  | stream N_IN features, stalls on x_valid=0
// ENC_DRAIN | wait ENC_LAT cycles for the encoder array
// REPARAM   | REPARAM_LAT cycles, strobe on first cycle
// DEC_FEED  | stream N_LAT latents, no stall
// DEC_DRAIN | wait DEC_LAT cycles for the decoder array
// DONE      | one-cycle done pulse
module vae_forward_sequencer
    import vae_ctrl_pkg::*;
#(
    parameter int N_IN        = VAE_N_IN,
    parameter int N_LAT       = VAE_N_LAT,
    parameter int ENC_LAT     = VAE_ENC_LAT,
    parameter int REPARAM_LAT = VAE_REPARAM_LAT,
    parameter int DEC_LAT     = VAE_DEC_LAT,
    parameter int CNT_W       = VAE_CNT_W,
    localparam int ENC_IDX_W  = (N_IN  > 1) ? $clog2(N_IN)  : 1,
    localparam int DEC_IDX_W  = (N_LAT > 1) ? $clog2(N_LAT) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 x_valid,
    output logic                 enc_clr,
    output logic                 dec_clr,
    output logic                 enc_en,
    output logic [ENC_IDX_W-1:0] enc_idx,
    output logic                 reparam_en,
    output logic                 dec_en,
    output logic [DEC_IDX_W-1:0] dec_idx,
    output logic                 busy,
    output logic                 done
);

    vae_state_t       state;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_expired;
    logic             do_abort;
    logic             enc_last;
    logic             dec_last;

    assign do_abort = abort && (state != IDLE);
    // enc_en is the registered "feature consumed this cycle" flag
    assign enc_last = (state == ENC_FEED) && enc_en && (enc_idx == ENC_IDX_W'(N_IN - 1));
    assign dec_last = (state == DEC_FEED) && (dec_idx == DEC_IDX_W'(N_LAT - 1));

    // Timer is loaded on the edge that enters each timed phase, so the
    // phase lasts exactly LAT cycles before expired is seen.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (do_abort) begin
            tmr_load = 1'b1;
        end else if (enc_last) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(ENC_LAT - 1);
        end else if (state == ENC_DRAIN && tmr_expired) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(REPARAM_LAT - 1);
        end else if (dec_last) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(DEC_LAT - 1);
        end
    end

    vae_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            enc_clr    <= 1'b0;
            dec_clr    <= 1'b0;
            enc_en     <= 1'b0;
            enc_idx    <= '0;
            reparam_en <= 1'b0;
            dec_en     <= 1'b0;
            dec_idx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            enc_clr    <= 1'b0;
            dec_clr    <= 1'b0;
            enc_en     <= 1'b0;
            reparam_en <= 1'b0;
            dec_en     <= 1'b0;
            done       <= 1'b0;
            if (do_abort) begin
                state   <= IDLE;
                enc_idx <= '0;
                dec_idx <= '0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state   <= CLR;
                            enc_clr <= 1'b1;
                            dec_clr <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                    CLR: begin
                        state  <= ENC_FEED;
                        enc_en <= x_valid;
                    end
                    ENC_FEED: begin
                        if (enc_last) begin
                            state   <= ENC_DRAIN;
                            enc_idx <= '0;
                        end else begin
                            if (enc_en) begin
                                enc_idx <= enc_idx + 1'b1;
                            end
                            enc_en <= x_valid;
                        end
                    end
                    ENC_DRAIN: begin
                        if (tmr_expired) begin
                            state      <= REPARAM;
                            reparam_en <= 1'b1;
                        end
                    end
                    REPARAM: begin
                        if (tmr_expired) begin
                            state  <= DEC_FEED;
                            dec_en <= 1'b1;
                        end
                    end
                    DEC_FEED: begin
                        if (dec_last) begin
                            state   <= DEC_DRAIN;
                            dec_idx <= '0;
                        end else begin
                            dec_idx <= dec_idx + 1'b1;
                            dec_en  <= 1'b1;
                        end
                    end
                    DEC_DRAIN: begin
                        if (tmr_expired) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vae_forward_sequencer.sv
module tb_vae_forward_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start_c, abort, x_valid;

    logic       enc_clr, dec_clr, enc_en, reparam_en, dec_en, busy, done;
    logic [3:0] enc_idx;
    logic [0:0] dec_idx;
    logic       enc_clr_c, dec_clr_c, enc_en_c, reparam_en_c, dec_en_c, busy_c, done_c;
    logic [3:0] enc_idx_c;
    logic [0:0] dec_idx_c;

    int errors = 0;
    int checks = 0;

    // expected per-cycle output vectors, cycle 1 = first cycle after start edge
    logic [11:0] exp_vec [0:99];
    bit          xv      [0:99];
    logic [11:0] obs, obs_c;

    always #5 clk = ~clk;

    vae_forward_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .x_valid(x_valid),
        .enc_clr(enc_clr), .dec_clr(dec_clr), .enc_en(enc_en), .enc_idx(enc_idx),
        .reparam_en(reparam_en), .dec_en(dec_en), .dec_idx(dec_idx),
        .busy(busy), .done(done)
    );

    vae_forward_sequencer #(
        .N_LAT(1), .ENC_LAT(1), .REPARAM_LAT(1), .DEC_LAT(1)
    ) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .abort(abort), .x_valid(x_valid),
        .enc_clr(enc_clr_c), .dec_clr(dec_clr_c), .enc_en(enc_en_c), .enc_idx(enc_idx_c),
        .reparam_en(reparam_en_c), .dec_en(dec_en_c), .dec_idx(dec_idx_c),
        .busy(busy_c), .done(done_c)
    );

    assign obs   = {enc_clr, dec_clr, enc_en, enc_idx, reparam_en, dec_en, dec_idx, busy, done};
    assign obs_c = {enc_clr_c, dec_clr_c, enc_en_c, enc_idx_c, reparam_en_c, dec_en_c,
                    dec_idx_c, busy_c, done_c};

    function automatic logic [11:0] mk(bit ec, bit dc, bit ee, int ei, bit re, bit de,
                                       int di, bit b, bit d);
        logic [3:0] ei4;
        logic [0:0] di1;
        ei4 = 4'(ei);
        di1 = 1'(di);
        return {ec, dc, ee, ei4, re, de, di1, b, d};
    endfunction

    // Reference: lay out one run cycle by cycle from the phase lengths.
    // xv[k] is the x_valid level seen at the edge ending cycle k.
    task automatic build_model(input int n_lat, input int el, input int rl, input int dl,
                               output int done_cyc);
        int c;
        int acc;
        for (int i = 0; i < 100; i++) exp_vec[i] = '0;
        exp_vec[1] = mk(1, 1, 0, 0, 0, 0, 0, 1, 0);
        c   = 2;
        acc = 0;
        while (acc < 9 && c < 80) begin
            exp_vec[c] = mk(0, 0, xv[c-1], acc, 0, 0, 0, 1, 0);
            if (xv[c-1]) acc++;
            c++;
        end
        for (int i = 0; i < el; i++) begin exp_vec[c] = mk(0,0,0,0,0,0,0,1,0); c++; end
        for (int i = 0; i < rl; i++) begin exp_vec[c] = mk(0,0,0,0,(i==0),0,0,1,0); c++; end
        for (int i = 0; i < n_lat; i++) begin exp_vec[c] = mk(0,0,0,0,0,1,i,1,0); c++; end
        for (int i = 0; i < dl; i++) begin exp_vec[c] = mk(0,0,0,0,0,0,0,1,0); c++; end
        exp_vec[c] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
        done_cyc = c;
    endtask

    task automatic fill_xv_ones();
        for (int i = 0; i < 100; i++) xv[i] = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 0; start_c = 0; abort = 0; x_valid = 0;
        #12;
        checks++;
        if (obs !== 12'h000) begin
            errors++; $display("FAIL reset_default got=%h exp=%h", obs, 12'h000);
        end
        checks++;
        if (obs_c !== 12'h000) begin
            errors++; $display("FAIL reset_corner got=%h exp=%h", obs_c, 12'h000);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_nominal(input string name, input int stall_at);
        int dcy;
        fill_xv_ones();
        if (stall_at > 0) begin
            for (int i = 0; i < 3; i++) xv[stall_at + i] = 1'b0;
        end
        build_model(2, 3, 4, 3, dcy);
        start = 1; x_valid = xv[0];
        @(posedge clk); #1;
        start = 0;
        for (int c = 1; c <= dcy + 2; c++) begin
            x_valid = xv[c];
            checks++;
            if (obs !== exp_vec[c]) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, obs, exp_vec[c]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random_stalls();
        int dcy;
        int done_at;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 100; i++)
                xv[i] = (i >= 25) ? 1'b1 : ($urandom_range(0, 3) != 0);
            build_model(2, 3, 4, 3, dcy);
            done_at = -1;
            start = 1; x_valid = xv[0];
            @(posedge clk); #1;
            start = 0;
            for (int c = 1; c <= dcy + 2; c++) begin
                x_valid = xv[c];
                if (done === 1'b1 && done_at < 0) done_at = c;
                checks++;
                if (obs !== exp_vec[c]) begin
                    errors++;
                    $display("FAIL random run=%0d cyc=%0d got=%h exp=%h", r, c, obs, exp_vec[c]);
                end
                @(posedge clk); #1;
            end
            checks++;
            if (done_at !== dcy) begin
                errors++;
                $display("FAIL random_done run=%0d got=%0d exp=%0d", r, done_at, dcy);
            end
        end
    endtask

    task automatic test_abort();
        int dcy;
        fill_xv_ones();
        build_model(2, 3, 4, 3, dcy);
        start = 1; x_valid = 1;
        @(posedge clk); #1;
        start = 0;
        for (int c = 1; c <= 35; c++) begin
            abort = (c == 15);
            checks++;
            if (c < 16) begin
                if (obs !== exp_vec[c]) begin
                    errors++; $display("FAIL abort_pre cyc=%0d got=%h exp=%h", c, obs, exp_vec[c]);
                end
            end else if (obs !== 12'h000) begin
                errors++; $display("FAIL abort_idle cyc=%0d got=%h exp=%h", c, obs, 12'h000);
            end
            @(posedge clk); #1;
        end
        abort = 0;
        test_nominal("abort_restart", 0);
    endtask

    task automatic test_async_reset();
        int dcy;
        fill_xv_ones();
        build_model(2, 3, 4, 3, dcy);
        start = 1; x_valid = 1;
        @(posedge clk); #1;
        start = 0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (obs !== exp_vec[c]) begin
                errors++; $display("FAIL areset_pre cyc=%0d got=%h exp=%h", c, obs, exp_vec[c]);
            end
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs !== 12'h000) begin
            errors++; $display("FAIL areset_immediate got=%h exp=%h", obs, 12'h000);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 30; c++) begin
            checks++;
            if (obs !== 12'h000) begin
                errors++; $display("FAIL areset_after cyc=%0d got=%h exp=%h", c, obs, 12'h000);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int dcy;
        logic [11:0] e;
        int clr_cnt;
        fill_xv_ones();
        build_model(2, 3, 4, 3, dcy);
        clr_cnt = 0;
        start = 1; x_valid = 1;
        @(posedge clk); #1;
        for (int c = 1; c <= 2 * dcy + 4; c++) begin
            start = (c < 30);
            if (c <= dcy)               e = exp_vec[c];
            else if (c == dcy + 1)      e = '0;
            else if (c <= 2 * dcy + 1)  e = exp_vec[c - dcy - 1];
            else                        e = '0;
            if (c <= dcy && enc_clr === 1'b1) clr_cnt++;
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", c, obs, e);
            end
            @(posedge clk); #1;
        end
        start = 0;
        checks++;
        if (clr_cnt !== 1) begin
            errors++; $display("FAIL b2b_clr_count got=%0d exp=%0d", clr_cnt, 1);
        end
    endtask

    task automatic test_corner();
        int dcy;
        int done_at;
        fill_xv_ones();
        build_model(1, 1, 1, 1, dcy);
        done_at = -1;
        start_c = 1; x_valid = 1;
        @(posedge clk); #1;
        start_c = 0;
        for (int c = 1; c <= dcy + 3; c++) begin
            if (done_c === 1'b1 && done_at < 0) done_at = c;
            checks++;
            if (obs_c !== exp_vec[c]) begin
                errors++; $display("FAIL corner cyc=%0d got=%h exp=%h", c, obs_c, exp_vec[c]);
            end
            if (dec_idx_c !== 1'b0) begin
                errors++; $display("FAIL corner_dec_idx cyc=%0d got=%0d exp=0", c, dec_idx_c);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (done_at !== 15) begin
            errors++; $display("FAIL corner_latency got=%0d exp=%0d", done_at, 15);
        end
    endtask

    initial begin
        test_reset();
        test_nominal("nominal", 0);
        test_nominal("stall", 5);
        test_random_stalls();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_corner();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vae_forward_sequencer.md
# vae_forward_sequencer

Control FSM for the NIDS-VAE forward pass. It sequences one inference through the encoder 2x1 mean/variance systolic arrays, the reparameterization stage (random sample, sqrt of variance, z = mean + sigma·eps), and the decoder 9x1 systolic array. It generates the clear and enable strobes and the weight/feature indices, and signals completion. It sits beside the forward datapath and replaces the free-running `start`/`clr` pins that are driven by hand today.

## Interface
- `N_IN`, 9: encoder input features (feed cycles).
- `N_LAT`, 2: latent dimensions (decoder feed cycles).
- `ENC_LAT`, 3: encoder drain cycles after the last feed, ≥1.
- `REPARAM_LAT`, 4: reparameterization cycles, ≥1.
- `DEC_LAT`, 3: decoder drain cycles after the last feed, ≥1.
- `CNT_W`, 8: latency counter width; every `*_LAT` must be < 2^CNT_W.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  asynchronous reset, active-low.
- `start`  in  1  request an inference; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; returns to IDLE.
- `x_valid`  in  1  feature source has `xj` for the current index.
- `enc_clr`  out  1  clear encoder accumulators.
- `dec_clr`  out  1  clear decoder accumulators.
- `enc_en`  out  1  encoder consumes `xj` and weights at `enc_idx`.
- `enc_idx`  out  $clog2(N_IN)  feature/weight index j.
- `reparam_en`  out  1  one-cycle strobe that latches the mean/var and steps the RNG.
- `dec_en`  out  1  decoder consumes the latent at `dec_idx`.
- `dec_idx`  out  max(1,$clog2(N_LAT))  latent/weight index i.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse; decoder outputs are valid.

## Operation
- States: IDLE → CLR → ENC_FEED → ENC_DRAIN → REPARAM → DEC_FEED → DEC_DRAIN → DONE → IDLE.
- All outputs are registered Moore outputs decoded from the state and counters.
- IDLE: all outputs 0. `start`=1 moves to CLR.
- CLR: one cycle with `enc_clr`=`dec_clr`=1.
- ENC_FEED: `enc_en`=`x_valid`. `enc_idx` starts at 0.
  - The index advances only on cycles where `x_valid`=1.
  - Accepting index N_IN-1 moves to ENC_DRAIN.
  - With `x_valid`=0, `enc_en`=0 and the index holds (stall).
- ENC_DRAIN: wait exactly ENC_LAT cycles, then go to REPARAM.
- REPARAM: lasts REPARAM_LAT cycles. `reparam_en`=1 on the first cycle only.
- DEC_FEED: `dec_en`=1 for N_LAT consecutive cycles, `dec_idx` 0..N_LAT-1. No stall.
- DEC_DRAIN: DEC_LAT cycles.
- DONE: `done`=1 for one cycle, then IDLE.
- Index counters wrap to 0 on phase exit. `enc_idx`/`dec_idx` read 0 outside their feed phase.
- `abort`=1 in any non-IDLE state: next state is IDLE, all counters are zeroed, and no `done` is produced. `abort` has priority over every other transition.
- `start` is ignored while `busy`=1, including in DONE. A `start` held high through DONE therefore launches the next run at the IDLE cycle after DONE.
- `start` and `abort` both high in IDLE: the run starts, because `abort` is ignored in IDLE.

## Timing
- Reset (`rst`=0): state IDLE, all outputs 0, all counters 0, applied asynchronously.
  - Reset mid-run discards the run; no `done`.
- Cycle numbering for `start` sampled at edge E0, no stalls, default parameters:
  - CLR in cycle 1.
  - `enc_en` in cycles 2–10.
  - ENC_DRAIN in cycles 11–13.
  - `reparam_en` in cycle 14; REPARAM occupies cycles 14–17.
  - `dec_en` in cycles 18–19.
  - DEC_DRAIN in cycles 20–22.
  - `done` in cycle 23.
- General latency: start-to-done = 1 + N_IN + S + ENC_LAT + REPARAM_LAT + N_LAT + DEC_LAT + 1 cycles, where S = number of stall cycles.
- `busy` rises in cycle 1 and falls after DONE. Back-to-back period is 24 cycles.
- Phase counters load LAT-1 on phase entry and exit when they reach 0.

## Structure
- Package `vae_ctrl_pkg` holds:
  - the state enum (`IDLE`, `CLR`, `ENC_FEED`, `ENC_DRAIN`, `REPARAM`, `DEC_FEED`, `DEC_DRAIN`, `DONE`);
  - default constants `VAE_N_IN`=9, `VAE_N_LAT`=2, `VAE_ENC_LAT`, `VAE_REPARAM_LAT`, `VAE_DEC_LAT`.
- Sub-module `vae_phase_timer`: a load/decrement/expire down-counter of width CNT_W. It is instantiated once and shared by the three drain/wait phases.
- Feed indices are separate counters in the top FSM.

## Test plan
- Nominal run: `start` pulse, `x_valid`=1 throughout. Required: `enc_en` high for exactly 9 cycles with `enc_idx` 0..8, `reparam_en` in cycle 14, `dec_en` in cycles 18–19, `done` a single pulse in cycle 23, `busy` low in cycle 24.
- Stall: `x_valid`=0 for 3 cycles while `enc_idx`=4. Required: `enc_en`=0 and `enc_idx` holds at 4 during the stall, and `done` moves to cycle 26.
- Abort: `abort` in cycle 15 (REPARAM). Required: IDLE with all outputs 0 in cycle 16, no `done`, and a new `start` is accepted normally.
- Async reset: `rst`=0 asserted in cycle 5, mid ENC_FEED. Required: all outputs 0 immediately, without waiting for a clock edge; after release, IDLE.
- Busy protection: `start` held high for 30 cycles. Required: first `done` in cycle 23, second run CLR in cycle 25, and no extra `enc_clr` during run one.
- Parameter corner: N_LAT=1, ENC_LAT=REPARAM_LAT=DEC_LAT=1. Required: start-to-done = 15 cycles, `dec_idx` always 0.
